// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
//
// Time-set controller for the digital clock. It conditions the raw mode and
// increment push-buttons (2-flop synchronizer, debouncer, rising-edge detect)
// and runs the RUN / SET_HOURS / SET_MINUTES state machine. It drives the
// counting enable, the seconds clear pulse, and the single-cycle increment
// strobes for the hours and minutes counters.
//
// Optional feature: define AUTO_REPEAT_EN to get auto-repeat increment strobes
// while the increment button is held in a set state. Without the macro, each
// press gives exactly one strobe and no repeat logic is built.
//
// Ports:
//   i_clk        in   system clock, the only clock
//   i_reset_n    in   asynchronous active-low reset
//   i_en         in   global enable (freezes the FSM and blocks strobes when low)
//   i_btn_mode   in   raw mode button, active-high, asynchronous
//   i_btn_inc    in   raw increment button, active-high, asynchronous
//   o_run_en     out  counting enable for the 1 Hz divider and counter chain
//   o_sec_clr    out  1-cycle pulse clearing seconds on SET_MINUTES -> RUN
//   o_min_inc    out  1-cycle increment strobe for the minutes counter
//   o_hour_inc   out  1-cycle increment strobe for the hours counter
//   o_mode       out  current state: 00 RUN, 01 SET_HOURS, 10 SET_MINUTES
// -----------------------------------------------------------------------------
module clock_set_ctrl #(
  parameter int DEBOUNCE_CYCLES      = 500_000,
  parameter int REPEAT_DELAY_CYCLES  = 25_000_000,
  parameter int REPEAT_PERIOD_CYCLES = 10_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_en,
  input  logic       i_btn_mode,
  input  logic       i_btn_inc,
  output logic       o_run_en,
  output logic       o_sec_clr,
  output logic       o_min_inc,
  output logic       o_hour_inc,
  output logic [1:0] o_mode
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN         = 2'b00,
    ST_SET_HOURS   = 2'b01,
    ST_SET_MINUTES = 2'b10
  } state_t;

  // Bit 0 is the mode button, bit 1 the increment button.
  logic [1:0] btn_raw;
  logic [1:0] btn_press;

  assign btn_raw = {i_btn_inc, i_btn_mode};

  // ---------------------------------------------------------------------------
  // Per-button conditioning: synchronizer, debouncer, rising-edge detect.
  // The debounce counter only runs while the synchronized level disagrees
  // with the accepted level; any agreeing cycle restarts it, so a change is
  // accepted only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic            sync1_reg;
      logic            sync2_reg;
      logic            db_reg;
      logic            db_prev_reg;
      logic [DB_W-1:0] cnt_reg;

      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          sync1_reg   <= 1'b0;
          sync2_reg   <= 1'b0;
          db_reg      <= 1'b0;
          db_prev_reg <= 1'b0;
          cnt_reg     <= '0;
        end else begin
          sync1_reg   <= btn_raw[gi];
          sync2_reg   <= sync1_reg;
          db_prev_reg <= db_reg;
          if (sync2_reg == db_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            db_reg  <= sync2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + DB_W'(1);
          end
        end
      end

      // Press event is high for the single cycle after the debounced level
      // rises; the previous-level flop updates regardless of i_en, so presses
      // seen while disabled are dropped rather than held.
      assign btn_press[gi] = db_reg & ~db_prev_reg;
    end
  endgenerate

  logic mode_press;
  logic inc_press;
  logic inc_event;

  assign mode_press = btn_press[0];
  assign inc_press  = btn_press[1];

  state_t state_reg;
  state_t state_next;

`ifdef AUTO_REPEAT_EN
  // ---------------------------------------------------------------------------
  // Auto-repeat timer. After the press strobe it waits REPEAT_DELAY_CYCLES,
  // then fires every REPEAT_PERIOD_CYCLES while the increment button stays
  // held in a set state. It is held cleared whenever the button is released,
  // the state is about to change, the FSM is in RUN, or i_en is low.
  // ---------------------------------------------------------------------------
  localparam int RP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                          REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RP_W = $clog2(RP_MAX + 1);
  localparam logic [RP_W-1:0] RP_DELAY_LAST  = RP_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_PERIOD_LAST = RP_W'(REPEAT_PERIOD_CYCLES - 1);

  logic            inc_level;
  logic            rep_active;
  logic            rep_fire;
  logic [RP_W-1:0] rep_limit;
  logic [RP_W-1:0] rep_cnt_reg;
  logic            rep_period_reg;  // 0: waiting initial delay, 1: periodic

  assign inc_level  = g_btn[1].db_reg;
  assign rep_active = i_en & inc_level & (state_reg != ST_RUN) & ~mode_press;
  assign rep_limit  = rep_period_reg ? RP_PERIOD_LAST : RP_DELAY_LAST;
  assign rep_fire   = rep_active & ~inc_press & (rep_cnt_reg == rep_limit);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rep_cnt_reg    <= '0;
      rep_period_reg <= 1'b0;
    end else if (!rep_active || inc_press) begin
      // The press itself produces the first strobe; start the delay phase.
      rep_cnt_reg    <= '0;
      rep_period_reg <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt_reg    <= '0;
      rep_period_reg <= 1'b1;
    end else begin
      rep_cnt_reg    <= rep_cnt_reg + RP_W'(1);
    end
  end

  assign inc_event = inc_press | rep_fire;
`else
  assign inc_event = inc_press;
`endif

  // ---------------------------------------------------------------------------
  // State machine. Strobes are registered so they line up with the state
  // register; a simultaneous mode press wins over an increment.
  // ---------------------------------------------------------------------------
  logic run_en_reg,   run_en_next;
  logic sec_clr_reg,  sec_clr_next;
  logic min_inc_reg,  min_inc_next;
  logic hour_inc_reg, hour_inc_next;

  always_comb begin
    state_next    = state_reg;
    sec_clr_next  = 1'b0;
    min_inc_next  = 1'b0;
    hour_inc_next = 1'b0;
    if (i_en) begin
      case (state_reg)
        ST_RUN: begin
          if (mode_press) state_next = ST_SET_HOURS;
        end
        ST_SET_HOURS: begin
          if (mode_press)     state_next    = ST_SET_MINUTES;
          else if (inc_event) hour_inc_next = 1'b1;
        end
        ST_SET_MINUTES: begin
          if (mode_press) begin
            state_next   = ST_RUN;
            sec_clr_next = 1'b1;
          end else if (inc_event) begin
            min_inc_next = 1'b1;
          end
        end
        default: state_next = ST_RUN;
      endcase
    end
    run_en_next = i_en & (state_next == ST_RUN);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg    <= ST_RUN;
      run_en_reg   <= 1'b0;
      sec_clr_reg  <= 1'b0;
      min_inc_reg  <= 1'b0;
      hour_inc_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      run_en_reg   <= run_en_next;
      sec_clr_reg  <= sec_clr_next;
      min_inc_reg  <= min_inc_next;
      hour_inc_reg <= hour_inc_next;
    end
  end

  assign o_run_en   = run_en_reg;
  assign o_sec_clr  = sec_clr_reg;
  assign o_min_inc  = min_inc_reg;
  assign o_hour_inc = hour_inc_reg;
  assign o_mode     = state_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
//
// Self-checking bench for clock_set_ctrl with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY_CYCLES=20, REPEAT_PERIOD_CYCLES=8. Button presses are described
// in a vector table with hand-computed outcomes; reset behaviour is covered by
// hand-written sequences. Expected values follow AUTO_REPEAT_EN if defined.
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

`ifdef AUTO_REPEAT_EN
  localparam int REP_N    = 6;   // strobes at +7,+27,+35,+43,+51,+59
  localparam int REP_LAST = 59;
  localparam int RST_EDGE = 27;  // reset just after the first repeat strobe
`else
  localparam int REP_N    = 1;
  localparam int REP_LAST = 7;
  localparam int RST_EDGE = 7;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       run_en;
  logic       sec_clr;
  logic       min_inc;
  logic       hour_inc;
  logic [1:0] mode;

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .DEBOUNCE_CYCLES      (DB),
    .REPEAT_DELAY_CYCLES  (RD),
    .REPEAT_PERIOD_CYCLES (RP)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_en       (en),
    .i_btn_mode (btn_mode),
    .i_btn_inc  (btn_inc),
    .o_run_en   (run_en),
    .o_sec_clr  (sec_clr),
    .o_min_inc  (min_inc),
    .o_hour_inc (hour_inc),
    .o_mode     (mode)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       mode_b;
    logic       inc_b;
    int         hold;       // edges the raw button is sampled high
    int         en_low;     // edges with i_en low at the start of the vector
    logic [1:0] exp_mode;
    int         exp_hour;
    int         exp_min;
    int         exp_clr;
    int         exp_first;  // edge index of first event, 0 = none
    int         exp_last;   // edge index of last event, 0 = none
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs[NVEC];

  task automatic run_vec(input int idx, input vec_t v);
    int         hour_n = 0;
    int         min_n  = 0;
    int         clr_n  = 0;
    int         first  = 0;
    int         last   = 0;
    int         bad    = 0;
    int         total;
    logic       en_at;
    logic [1:0] prev_mode;
    total = v.hold + 16;
    @(negedge clk);
    btn_mode  = v.mode_b;
    btn_inc   = v.inc_b;
    en        = (v.en_low > 0) ? 1'b0 : 1'b1;
    prev_mode = mode;
    for (int k = 1; k <= total; k++) begin
      @(posedge clk);
      en_at = en;
      #1;
      if (hour_inc || min_inc || sec_clr || (mode != prev_mode)) begin
        if (first == 0) first = k;
        last = k;
      end
      if (hour_inc) hour_n++;
      if (min_inc)  min_n++;
      if (sec_clr)  clr_n++;
      if (hour_inc && min_inc) bad++;
      if (run_en !== (en_at && (mode == 2'b00))) bad++;
      if (sec_clr && !(prev_mode == 2'b10 && mode == 2'b00)) bad++;
      if (mode == 2'b11) bad++;
      prev_mode = mode;
      if (k == v.hold) begin
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
      end
      if (k == v.en_low) en = 1'b1;
    end
    $display("vec %0d: mode_b=%0b inc_b=%0b hold=%0d en_low=%0d -> mode=%0d hour=%0d min=%0d clr=%0d first=%0d last=%0d",
             idx, v.mode_b, v.inc_b, v.hold, v.en_low, mode, hour_n, min_n, clr_n, first, last);
    check($sformatf("vec%0d mode", idx),       32'(mode),   32'(v.exp_mode));
    check($sformatf("vec%0d hour_inc", idx),   32'(hour_n), 32'(v.exp_hour));
    check($sformatf("vec%0d min_inc", idx),    32'(min_n),  32'(v.exp_min));
    check($sformatf("vec%0d sec_clr", idx),    32'(clr_n),  32'(v.exp_clr));
    check($sformatf("vec%0d first_edge", idx), 32'(first),  32'(v.exp_first));
    check($sformatf("vec%0d last_edge", idx),  32'(last),   32'(v.exp_last));
    check($sformatf("vec%0d invariants", idx), 32'(bad),    32'd0);
  endtask

  initial begin
    //          mode inc  hold en_low mode  hr min clr first last
    vecs[0] = '{1'b0, 1'b1, 6,  0, 2'b00, 0, 0,     0, 0, 0};         // inc in RUN ignored
    vecs[1] = '{1'b1, 1'b0, 10, 0, 2'b01, 0, 0,     0, 7, 7};         // RUN -> SET_HOURS
    vecs[2] = '{1'b0, 1'b1, 3,  0, 2'b01, 0, 0,     0, 0, 0};         // glitch filtered
    vecs[3] = '{1'b0, 1'b1, 6,  0, 2'b01, 1, 0,     0, 7, 7};         // one hour strobe
    vecs[4] = '{1'b1, 1'b1, 10, 0, 2'b10, 0, 0,     0, 7, 7};         // mode wins over inc
    vecs[5] = '{1'b0, 1'b1, 60, 0, 2'b10, 0, REP_N, 0, 7, REP_LAST};  // held inc in SET_MINUTES
    vecs[6] = '{1'b1, 1'b0, 10, 0, 2'b00, 0, 0,     1, 7, 7};         // back to RUN, sec clear
    vecs[7] = '{1'b1, 1'b0, 10, 10, 2'b00, 0, 0,    0, 0, 0};         // press while disabled dropped
    vecs[8] = '{1'b1, 1'b0, 10, 0, 2'b01, 0, 0,     0, 7, 7};
    vecs[9] = '{1'b1, 1'b0, 10, 0, 2'b10, 0, 0,     0, 7, 7};

    // Reset state held over several edges.
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset mode",     32'(mode),     32'd0);
    check("reset run_en",   32'(run_en),   32'd0);
    check("reset sec_clr",  32'(sec_clr),  32'd0);
    check("reset min_inc",  32'(min_inc),  32'd0);
    check("reset hour_inc", 32'(hour_inc), 32'd0);

    // Release: run_en rises on the first edge, then idle quietly.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first edge run_en", 32'(run_en), 32'd1);
    begin
      int strobes = 0;
      int not_run = 0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk);
        #1;
        if (sec_clr || min_inc || hour_inc) strobes++;
        if (!run_en || mode != 2'b00) not_run++;
      end
      $display("idle: strobes=%0d not_run=%0d", strobes, not_run);
      check("idle strobes", 32'(strobes), 32'd0);
      check("idle run",     32'(not_run), 32'd0);
    end

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // Reset asserted mid-repeat in SET_MINUTES while a strobe is high.
    @(negedge clk);
    btn_inc = 1'b1;
    for (int k = 1; k <= RST_EDGE; k++) begin
      @(posedge clk);
      #1;
    end
    check("pre-reset min_inc", 32'(min_inc), 32'd1);
    check("pre-reset mode",    32'(mode),    32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: mode=%0d run_en=%0b min_inc=%0b hour_inc=%0b sec_clr=%0b",
             mode, run_en, min_inc, hour_inc, sec_clr);
    check("async reset mode",    32'(mode),    32'd0);
    check("async reset min_inc", 32'(min_inc), 32'd0);
    check("async reset run_en",  32'(run_en),  32'd0);
    btn_inc = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset mode",   32'(mode),   32'd0);
    check("post-reset run_en", 32'(run_en), 32'd1);
    begin
      int strobes = 0;
      for (int k = 0; k < 12; k++) begin
        @(posedge clk);
        #1;
        if (sec_clr || min_inc || hour_inc || mode != 2'b00) strobes++;
      end
      $display("post-reset idle: events=%0d", strobes);
      check("post-reset idle", 32'(strobes), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
